pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC and address width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the PC value held in reset.
REQ-003 The block SHALL have parameter IALIGN, default 4, giving the instruction alignment and sequential step in bytes; legal values are 2 and 4.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address-stack entries; legal values are powers of two, 2 or more.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 stall  input  1  hold the PC and the RAS.
REQ-008 trap_valid  input  1  exception request.
REQ-009 trap_vector  input  WIDTH  exception handler address.
REQ-010 redirect_valid  input  1  taken branch or jump.
REQ-011 redirect_target  input  WIDTH  branch or jump target.
REQ-012 call  input  1  push the return address; only qualified by redirect_valid.
REQ-013 ret  input  1  pop the predicted return address.
REQ-014 PC  output  WIDTH  current PC, registered.
REQ-015 PCPlus  output  WIDTH  PC+IALIGN, combinational, modulo 2^WIDTH.
REQ-016 misaligned  output  1  registered one-cycle pulse flagging a rejected misaligned redirect.
REQ-017 ras_underflow  output  1  registered one-cycle pulse flagging ret on an empty RAS.
REQ-018 ras_count  output  $clog2(RAS_DEPTH)+1  number of valid RAS entries.

Function
REQ-019 Next-PC priority SHALL be: trap_valid, then redirect_valid, then ret, then stall, then sequential.
- trap_valid: PC <= trap_vector, whether or not stall is set.
- redirect_valid with an aligned target: PC <= redirect_target, whether or not stall is set.
- ret with a non-empty RAS: PC <= top entry.
- stall: PC holds.
- Otherwise: PC <= PCPlus.
REQ-020 A redirect_target is aligned when target mod IALIGN == 0; the mod is taken on the low bits.
REQ-021 A misaligned redirect SHALL NOT be taken.
- Instead: PC <= trap_vector, and misaligned pulses high in the cycle after the edge.
REQ-022 PCPlus SHALL wrap modulo 2^WIDTH, so all-ones minus (IALIGN-1) steps to 0 with no flag.
REQ-023 call SHALL be honoured only with redirect_valid, no trap_valid and an aligned target.
- On a push, the value PCPlus SHALL be written at top+1.
REQ-024 When the RAS is full, a push SHALL overwrite the oldest entry (circular pointer); ras_count saturates at RAS_DEPTH.
REQ-025 ret SHALL be honoured only when trap_valid=0, redirect_valid=0 and stall=0.
- Non-empty: pop, ras_count decrements, PC <= popped value.
- Empty: PC <= PCPlus, ras_underflow pulses, count stays 0.
REQ-026 call and ret asserted together SHALL resolve with the redirect winning the PC.
- The ret is ignored.
- The push proceeds.
REQ-027 trap_valid SHALL leave the RAS contents and ras_count unchanged.
REQ-028 While stall=1 without trap or redirect, PC, the RAS, ras_count, misaligned and ras_underflow SHALL hold or be 0.
- Pulses are 0 in that cycle.
REQ-029 PC update latency SHALL be exactly one clock edge after the qualifying inputs, with no bubble cycles.

Reset
REQ-030 While rst=1, PC SHALL equal RESET_VECTOR immediately, without waiting for clk.
REQ-031 While rst=1, ras_count SHALL be 0, RAS pointers 0, and misaligned and ras_underflow 0.
REQ-032 Assertion of rst mid-operation, including mid-stall or the same cycle as trap or redirect, SHALL override all inputs.
REQ-033 On the first rising edge after rst falls with no other input active, PC SHALL become RESET_VECTOR+IALIGN.

Verification
REQ-034 Reset and sequential: rst pulse between edges -> PC=0 at once; 3 free edges -> PC=4, 8, 0xC.
REQ-035 Priority: at PC=0x100, trap_valid=1 (vector 0x80) + redirect_valid=1 (0x200) + stall=1 -> PC=0x80; redirect alone under stall -> 0x200; stall alone -> holds.
REQ-036 Misaligned redirect: redirect_target=0x202 with IALIGN=4, trap_vector=0x80 -> PC=0x80, misaligned=1 for exactly one cycle.
REQ-037 RAS round-trip: at PC=0x10, call+redirect to 0x400 -> PC=0x400, ras_count=1; ret at 0x404 -> PC=0x14, ras_count=0; second ret -> PC=PCPlus, ras_underflow=1.
REQ-038 RAS overflow with RAS_DEPTH=4: 5 calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> ras_count=4; 4 rets -> 0x404, 0x304, 0x204, 0x104; 5th ret -> underflow.
REQ-039 Wrap and random: PC=0xFFFF_FFFC -> next PC=0; 1000 random constrained cycles against a reference model -> PC and flags match every cycle, with an async rst injected mid-run.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with trap/redirect/return priority select
// and a circular return-address stack for call/return prediction.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               IALIGN       = 4,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         stall,
   input  logic                         trap_valid,
   input  logic [WIDTH-1:0]             trap_vector,
   input  logic                         redirect_valid,
   input  logic [WIDTH-1:0]             redirect_target,
   input  logic                         call,
   input  logic                         ret,
   output logic [WIDTH-1:0]             PC,
   output logic [WIDTH-1:0]             PCPlus,
   output logic                         misaligned,
   output logic                         ras_underflow,
   output logic [$clog2(RAS_DEPTH):0]   ras_count
);

   localparam int               PW    = $clog2(RAS_DEPTH);
   localparam logic [WIDTH-1:0] AMASK = WIDTH'(IALIGN - 1);
   localparam logic [WIDTH-1:0] STEP  = WIDTH'(IALIGN);
   localparam logic [PW:0]      FULL  = (PW+1)'(RAS_DEPTH);
   localparam logic [PW:0]      ONE_C = 1;
   localparam logic [PW-1:0]    ONE_P = 1;

   logic [WIDTH-1:0] ras [RAS_DEPTH];
   logic [PW-1:0]    top;
   logic [PW-1:0]    top_inc;
   logic [PW-1:0]    top_nxt;
   logic [PW:0]      cnt_nxt;
   logic [WIDTH-1:0] pc_nxt;
   logic             aligned;
   logic             sel_trap;
   logic             sel_redir;
   logic             sel_ret;
   logic             sel_hold;
   logic             push;
   logic             pop;
   logic             mis_nxt;
   logic             unf_nxt;

   assign PCPlus  = PC + STEP;
   assign aligned = (redirect_target & AMASK) == '0;
   assign top_inc = top + ONE_P;

   // Mutually exclusive selects encode the fixed next-PC priority.
   assign sel_trap  = trap_valid;
   assign sel_redir = !trap_valid && redirect_valid;
   assign sel_ret   = !trap_valid && !redirect_valid && ret && !stall;
   assign sel_hold  = !trap_valid && !redirect_valid && stall;

   // Next-PC, stack operation and flag decode.
   always_comb begin
      pc_nxt  = PCPlus;
      push    = 1'b0;
      pop     = 1'b0;
      mis_nxt = 1'b0;
      unf_nxt = 1'b0;
      top_nxt = top;
      cnt_nxt = ras_count;
      unique case (1'b1)
         sel_trap: pc_nxt = trap_vector;
         sel_redir: begin
            if (aligned) begin
               pc_nxt = redirect_target;
               push   = call;
            end else begin
               pc_nxt  = trap_vector;
               mis_nxt = 1'b1;
            end
         end
         sel_ret: begin
            if (ras_count != '0) begin
               pc_nxt = ras[top];
               pop    = 1'b1;
            end else begin
               unf_nxt = 1'b1;
            end
         end
         sel_hold: pc_nxt = PC;
         default:  pc_nxt = PCPlus;
      endcase
      if (push) begin
         top_nxt = top_inc;
         cnt_nxt = (ras_count == FULL) ? FULL : ras_count + ONE_C;
      end else if (pop) begin
         top_nxt = top - ONE_P;
         cnt_nxt = ras_count - ONE_C;
      end
   end

   // PC, stack pointer, occupancy and pulse flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         PC            <= RESET_VECTOR;
         top           <= '0;
         ras_count     <= '0;
         misaligned    <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         PC            <= pc_nxt;
         top           <= top_nxt;
         ras_count     <= cnt_nxt;
         misaligned    <= mis_nxt;
         ras_underflow <= unf_nxt;
      end
   end

   // Stack storage; a push into a full stack overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (push && !rst)
         ras[top_inc] <= PCPlus;
   end

endmodule
